// File: rtl/call_register.sv
// rtl/call_register.sv - debounced call latch for in-car and hall buttons
// Raw buttons are synchronized, debounced, and rising edges latch pending calls.
module call_register #(
   parameter int FLOORS   = 8,
   parameter int DEBOUNCE = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [FLOORS-1:0]                btn_in,
   input  logic [FLOORS-1:0]                btn_up_out,
   input  logic [FLOORS-1:0]                btn_down_out,
   input  logic [FLOORS-1:0]                inactivate_in_levels,
   input  logic [FLOORS-1:0]                inactivate_out_up_levels,
   input  logic [FLOORS-1:0]                inactivate_out_down_levels,
   input  logic [$clog2(FLOORS)-1:0]        cur_floor,
   output logic [FLOORS-1:0]                active_in_levels,
   output logic [FLOORS-1:0]                active_out_up_levels,
   output logic [FLOORS-1:0]                active_out_down_levels,
   output logic                             req_above,
   output logic                             req_here,
   output logic                             req_below,
   output logic [$clog2(3*FLOORS+1)-1:0]    pending_cnt,
   output logic                             new_req
);

   localparam int N    = 3 * FLOORS;
   localparam int CW   = $clog2(DEBOUNCE + 1);
   localparam int PCW  = $clog2(3 * FLOORS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
   localparam logic [N-1:0]  ONE      = N'(1);
   // Top-floor up and ground-floor down calls are meaningless; their debouncers still run.
   localparam logic [N-1:0]  SET_ALLOW = ~((ONE << (2*FLOORS-1)) | (ONE << (2*FLOORS)));

   logic [N-1:0]          raw, inact;
   logic [N-1:0]          sync1_q, sync2_q;
   logic [N-1:0]          stable_q, stable_d;
   logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]          active_q, active_d;
   logic [N-1:0]          rise;
   logic                  new_req_q, new_req_d;
   logic [FLOORS-1:0]     level_any;
   logic [31:0]           floor_ext;
   logic                  in_range;
   logic                  above_any, here_any, below_any;
   logic [PCW-1:0]        popcnt;

   assign raw   = {btn_down_out, btn_up_out, btn_in};
   assign inact = {inactivate_out_down_levels, inactivate_out_up_levels, inactivate_in_levels};

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      rise     = '0;
      for (int i = 0; i < N; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
               rise[i]     = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      // A set on the same edge as a clear wins.
      active_d  = (rise & SET_ALLOW) | (active_q & ~inact);
      new_req_d = |(active_d & ~active_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         cnt_q     <= '0;
         active_q  <= '0;
         new_req_q <= 1'b0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         new_req_q <= new_req_d;
      end
   end

   assign active_in_levels       = active_q[FLOORS-1:0];
   assign active_out_up_levels   = active_q[2*FLOORS-1:FLOORS];
   assign active_out_down_levels = active_q[3*FLOORS-1:2*FLOORS];
   assign new_req                = new_req_q;

   always_comb begin
      popcnt = '0;
      for (int i = 0; i < N; i++) begin
         popcnt = popcnt + PCW'(active_q[i]);
      end
   end
   assign pending_cnt = popcnt;

   assign level_any = active_in_levels | active_out_up_levels | active_out_down_levels;
   assign floor_ext = 32'(cur_floor);
   assign in_range  = floor_ext < 32'(FLOORS);

   always_comb begin
      above_any = 1'b0;
      here_any  = 1'b0;
      below_any = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (32'(i) > floor_ext)  above_any = above_any | level_any[i];
         if (32'(i) == floor_ext) here_any  = here_any  | level_any[i];
         if (32'(i) < floor_ext)  below_any = below_any | level_any[i];
      end
   end

   assign req_above = in_range & above_any;
   assign req_here  = in_range & here_any;
   assign req_below = in_range & below_any;

endmodule
